// File: rtl/pipelined_rca_addsub_pkg.sv
// Shared constants for the pipelined ripple-carry adder/subtractor.
package pipelined_rca_addsub_pkg;

    localparam int   DEF_WIDTH  = 32;
    localparam int   DEF_STAGES = 4;
    localparam int   DEF_SLICE  = DEF_WIDTH / DEF_STAGES;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/pipelined_rca_addsub_rca_slice.sv
// Combinational WIDTH-bit ripple-carry adder; one carry slice of the pipeline.
module rca_slice
    import pipelined_rca_addsub_pkg::*;
#(
    parameter int WIDTH = DEF_SLICE
) (
    output logic             c_out,
    output logic [WIDTH-1:0] sum,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in
);

    always_comb begin : ripple
        logic cy;
        cy  = c_in;
        sum = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = a[i] ^ b[i] ^ cy;
            cy     = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
        end
        c_out = cy;
    end

endmodule

// File: rtl/pipelined_rca_addsub.sv
// Pipelined add/sub: one carry slice per stage, skewed operands, valid/ready with a global stall.
module pipelined_rca_addsub
    import pipelined_rca_addsub_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int SLICE = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    logic                         stall;
    logic [STAGES:0]              vld_pipe;
    logic [STAGES-1:0]            vld_d, vld_q;

    // Per-stage operand/partial-sum views; stage k consumes slice k.
    logic [STAGES-1:0][WIDTH-1:0] a_src, b_src, s_src, s_d, s_q;
    logic [STAGES-1:0]            cy_src, cy_d, cy_q;
    logic [STAGES-1:0][SLICE-1:0] sl_a, sl_b, sl_sum;
    logic [STAGES-1:0]            sl_cout;
    logic                         msb_cin, ovf_d, ovf_q, zero_d, zero_q;

    assign stall     = vld_pipe[STAGES] & ~out_ready;
    assign in_ready  = ~stall;
    assign vld_pipe  = {vld_q, in_valid & in_ready};
    assign out_valid = vld_pipe[STAGES];

    assign a_src[0] = a;
    assign b_src[0] = (op_sub == OP_SUB) ? ~b : b;

    generate
        if (STAGES > 1) begin : g_skew
            logic [STAGES-2:0][WIDTH-1:0] a_d, a_q, b_d, b_q;

            // Consumed slices are zeroed so only the pending upper slices are really stored.
            always_comb begin
                a_d = '0;
                b_d = '0;
                for (int k = 0; k < STAGES - 1; k++) begin
                    a_d[k] = a_src[k] & ({WIDTH{1'b1}} << ((k + 1) * SLICE));
                    b_d[k] = b_src[k] & ({WIDTH{1'b1}} << ((k + 1) * SLICE));
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (!stall) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end

            assign a_src[STAGES-1:1] = a_q;
            assign b_src[STAGES-1:1] = b_q;
        end
    endgenerate

    always_comb begin
        s_src     = '0;
        cy_src    = '0;
        cy_src[0] = (op_sub == OP_SUB) ? 1'b1 : c_in;
        for (int k = 1; k < STAGES; k++) begin
            s_src[k]  = s_q[k-1];
            cy_src[k] = cy_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            sl_a[k] = SLICE'(a_src[k] >> (k * SLICE));
            sl_b[k] = SLICE'(b_src[k] >> (k * SLICE));
        end
    end

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_slice
            rca_slice #(.WIDTH(SLICE)) u_rca (
                .c_out (sl_cout[k]),
                .sum   (sl_sum[k]),
                .a     (sl_a[k]),
                .b     (sl_b[k]),
                .c_in  (cy_src[k])
            );
        end
    endgenerate

    always_comb begin
        vld_d = vld_pipe[STAGES-1:0];
        cy_d  = sl_cout;
        s_d   = '0;
        for (int k = 0; k < STAGES; k++) begin
            s_d[k] = s_src[k] | (WIDTH'(sl_sum[k]) << (k * SLICE));
        end
        // Carry into the MSB recovered from its sum bit: s = a ^ b ^ cin.
        msb_cin = sl_a[LAST][SLICE-1] ^ sl_b[LAST][SLICE-1] ^ sl_sum[LAST][SLICE-1];
        ovf_d   = msb_cin ^ sl_cout[LAST];
        zero_d  = ~|s_d[LAST];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            s_q    <= '0;
            cy_q   <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (!stall) begin
            vld_q  <= vld_d;
            s_q    <= s_d;
            cy_q   <= cy_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign sum   = s_q[LAST];
    assign c_out = cy_q[LAST];
    assign ovf   = ovf_q;
    assign zero  = zero_q;

endmodule

// File: tb/tb_pipelined_rca_addsub.sv
// Directed + randomised bench for pipelined_rca_addsub against an arithmetic reference model.
module tb_pipelined_rca_addsub;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;
    localparam int NRAND  = 10000;

    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        o;
        logic        z;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        c_in;
    logic        op_sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        c_out;
    logic        ovf;
    logic        zero;

    int          tests = 0;
    int          fails = 0;
    res_t        exp_q[$];
    logic [31:0] got_q[$];
    res_t        mon_e;

    always #5 clk = ~clk;

    pipelined_rca_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf),
        .zero      (zero)
    );

    // Reference: plain unsigned/signed arithmetic on wide integers.
    function automatic res_t model(input logic [31:0] x, input logic [31:0] y,
                                   input logic ci, input logic sub);
        res_t        r;
        longint      sx, sy, sr;
        logic [32:0] u;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (sub) begin
            u   = {1'b0, x} - {1'b0, y};
            r.c = (x >= y);
            sr  = sx - sy;
        end else begin
            u   = {1'b0, x} + {1'b0, y} + {32'd0, ci};
            r.c = u[32];
            sr  = sx + sy + longint'(ci);
        end
        r.s = u[31:0];
        r.o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        r.z = (r.s == 32'd0);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    // Compare process: every output cycle is checked against the head of the model queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            chk1("rst_out_valid", out_valid, 1'b0);
            chk("rst_sum", sum, 32'd0);
            chk1("rst_c_out", c_out, 1'b0);
            chk1("rst_ovf", ovf, 1'b0);
            chk1("rst_zero", zero, 1'b0);
        end else begin
            chk1("in_ready", in_ready, !(out_valid && !out_ready));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk1("spurious_out_valid", out_valid, 1'b0);
                end else begin
                    mon_e = exp_q[0];
                    chk("out_sum", sum, mon_e.s);
                    chk1("out_c_out", c_out, mon_e.c);
                    chk1("out_ovf", ovf, mon_e.o);
                    chk1("out_zero", zero, mon_e.z);
                    if (out_ready) begin
                        got_q.push_back(sum);
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, c_in, op_sub));
        end
    end

    task automatic send(input logic [31:0] ta, input logic [31:0] tb_,
                        input logic tc, input logic ts);
        bit acc;
        int n;
        a = ta; b = tb_; c_in = tc; op_sub = ts; in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            n++;
            @(posedge clk); #1;
        end while (!acc && n < 50);
        if (!acc) chk1("send_timeout", 1'b0, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic run_one(input string nm, input logic [31:0] ta, input logic [31:0] tb_,
                           input logic tc, input logic ts, input logic [31:0] es,
                           input logic ec, input logic eo, input logic ez);
        res_t m;
        int   lat;
        m = model(ta, tb_, tc, ts);
        chk({nm, "_model_sum"}, m.s, es);
        chk1({nm, "_model_c"}, m.c, ec);
        chk1({nm, "_model_ovf"}, m.o, eo);
        chk1({nm, "_model_zero"}, m.z, ez);
        send(ta, tb_, tc, ts);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 30);
        chk({nm, "_latency"}, 32'(lat), 32'(STAGES));
        chk({nm, "_sum"}, sum, es);
        chk1({nm, "_c_out"}, c_out, ec);
        chk1({nm, "_ovf"}, ovf, eo);
        chk1({nm, "_zero"}, zero, ez);
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit acc;
        int n;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c_in = 1'b0; op_sub = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk1("in_ready_after_rst", in_ready, 1'b1);
        chk1("out_valid_after_rst", out_valid, 1'b0);
        @(posedge clk); #1;

        run_one("add_wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run_one("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run_one("sub_pos",    32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
        run_one("add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        run_one("add_xslice", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
        run_one("add_cin",    32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 32'h0000_0004, 1'b0, 1'b0, 1'b0);
        run_one("sub_ign_ci", 32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run_one("sub_ovf",    32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

        // Back-to-back stream with out_ready low on cycles 5..7.
        got_q.delete();
        fork
            begin
                for (int i = 0; i < 8; i++) send(32'(i), 32'(32'h100 * i), 1'b0, 1'b0);
            end
            begin
                for (int j = 0; j < 16; j++) begin
                    out_ready = !(j >= 5 && j <= 7);
                    @(posedge clk); #1;
                end
            end
        join
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk("stream_count", 32'(got_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < got_q.size(); i++) chk("stream_val", got_q[i], 32'(32'h101 * i));

        // Reset while results are in flight.
        send(32'd10, 32'd1, 1'b0, 1'b0);
        send(32'd20, 32'd2, 1'b0, 1'b0);
        send(32'd30, 32'd3, 1'b0, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 30);
        chk1("pre_rst_valid", out_valid, 1'b1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk1("mid_rst_valid_drop", out_valid, 1'b0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk1("post_rst_quiet", out_valid, 1'b0);
        end
        @(posedge clk); #1;
        run_one("post_rst_add", 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0, 1'b0);

        // Random mixed traffic with random backpressure.
        n = 0;
        while (n < NRAND) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) n++;
            if (acc || !in_valid) begin
                if (n < NRAND && $urandom_range(0, 4) != 0) begin
                    in_valid = 1'b1;
                    a        = pick();
                    b        = pick();
                    c_in     = 1'($urandom_range(0, 1));
                    op_sub   = 1'($urandom_range(0, 1));
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
